// File: rtl/fifo_axis_packetizer_if.sv
// rtl/fifo_axis_packetizer_if.sv - FIFO read port and AXI4-Stream master bundle for the packetizer
interface fifo_axis_packetizer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  o_fifo_rd_en;
    logic                  i_fifo_empty;
    logic [DATA_WIDTH-1:0] i_fifo_rd_data;
    logic                  i_fifo_rd_valid;
    logic [DATA_WIDTH-1:0] o_m_axis_tdata;
    logic                  o_m_axis_tvalid;
    logic                  o_m_axis_tlast;
    logic                  i_m_axis_tready;

    modport master (
        output o_fifo_rd_en, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast,
        input  i_fifo_empty, i_fifo_rd_data, i_fifo_rd_valid, i_m_axis_tready
    );

    modport slave (
        input  o_fifo_rd_en, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast,
        output i_fifo_empty, i_fifo_rd_data, i_fifo_rd_valid, i_m_axis_tready
    );
endinterface

// File: rtl/fifo_axis_packetizer.sv
// rtl/fifo_axis_packetizer.sv - pulls words from a sync FIFO and emits fixed-length AXI4-Stream packets
module fifo_axis_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_a_rst,
    input  logic                 i_enable,
    input  logic [LEN_WIDTH-1:0] i_pkt_len,
    fifo_axis_packetizer_if.master bus,
    output logic                 o_busy,
    output logic                 o_pkt_done
);
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]  req_cnt_q, req_cnt_d;
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            in_flight_q, in_flight_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic                  tvalid, tlast, pop, push, rd_en, wr_ptr;
    logic [2:0]            slots_used;
    logic [LEN_WIDTH-1:0]  start_len;

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            req_cnt_q   <= '0;
            occ_q       <= '0;
            in_flight_q <= '0;
            rd_ptr_q    <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            req_cnt_q   <= req_cnt_d;
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

    always_comb begin
        tvalid     = (occ_q != 2'd0);
        tlast      = tvalid && (beat_cnt_q == len_q - LEN_WIDTH'(1));
        pop        = tvalid && bus.i_m_axis_tready;
        // Only accept returned words we actually asked for; this drops reads issued before a reset.
        push       = bus.i_fifo_rd_valid && (in_flight_q != 2'd0);
        // A beat leaving this cycle frees its slot, which keeps one-beat-per-clock streaming.
        slots_used = {1'b0, occ_q} + {1'b0, in_flight_q} - {2'b00, pop};
        rd_en      = (state_q == ST_RUN) && !bus.i_fifo_empty
                     && (slots_used < 3'd2) && (req_cnt_q < len_q);
        wr_ptr     = rd_ptr_q ^ occ_q[0];
        start_len  = (i_pkt_len == '0) ? LEN_WIDTH'(1) : i_pkt_len;

        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        if (push) begin
            buf_d[wr_ptr] = bus.i_fifo_rd_data;
        end
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        in_flight_d = in_flight_q + {1'b0, rd_en} - {1'b0, push};
        rd_ptr_d    = rd_ptr_q ^ pop;

        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(pop);
        req_cnt_d  = req_cnt_q + LEN_WIDTH'(rd_en);

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d    = ST_RUN;
                    len_d      = start_len;
                    beat_cnt_d = '0;
                    req_cnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (pop && tlast) begin
                    beat_cnt_d = '0;
                    req_cnt_d  = '0;
                    if (i_enable) begin
                        len_d = start_len;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus.o_fifo_rd_en    = rd_en;
        bus.o_m_axis_tvalid = tvalid;
        bus.o_m_axis_tlast  = tlast;
        bus.o_m_axis_tdata  = tvalid ? buf_q[rd_ptr_q] : '0;
        o_busy              = (state_q == ST_RUN);
        o_pkt_done          = pop && tlast;
    end
endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// tb/tb_fifo_axis_packetizer.sv - table-driven scoreboard bench for fifo_axis_packetizer
module tb_fifo_axis_packetizer;
    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [LW-1:0] pkt_len;
    logic          busy, pkt_done;

    fifo_axis_packetizer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_axis_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk      (clk),
        .i_a_rst    (rst),
        .i_enable   (enable),
        .i_pkt_len  (pkt_len),
        .bus        (bus.master),
        .o_busy     (busy),
        .o_pkt_done (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int       len;
        int       words;
        bit [3:0] rdy;
        bit       hold;
        int       stall_after;
        int       stall_len;
        int       exp_pkts;
        int       exp_span;
    } vec_t;

    logic [DW-1:0] fifo_q[$];
    beat_t         sb_q[$];
    vec_t          vecs[6];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, beats, dones, rdens, tv_cnt;
    int first_hs, last_hs, first_rd, first_tv;
    logic ready_now, stall_now;
    logic samp_tvalid, samp_busy;
    logic prev_stall_v, prev_l;
    logic [DW-1:0] prev_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; beats = 0; dones = 0; rdens = 0; tv_cnt = 0;
        first_hs = -1; last_hs = -1; first_rd = -1; first_tv = -1;
        prev_stall_v = 1'b0;
    endtask

    // One clock: drive at negedge, sample 1 ns later, then model the FIFO's one-cycle read latency.
    task automatic tick();
        bit    rd;
        bit    hs;
        beat_t e;
        logic  exp_done;
        bus.i_fifo_empty    = stall_now || (fifo_q.size() == 0);
        bus.i_m_axis_tready = ready_now;
        #1;
        samp_tvalid = bus.o_m_axis_tvalid;
        samp_busy   = busy;
        if (prev_stall_v) begin
            check("stall_tvalid", bus.o_m_axis_tvalid, 1);
            check("stall_tdata", bus.o_m_axis_tdata, prev_d);
            check("stall_tlast", bus.o_m_axis_tlast, prev_l);
        end
        prev_stall_v = bus.o_m_axis_tvalid && !bus.i_m_axis_tready;
        prev_d       = bus.o_m_axis_tdata;
        prev_l       = bus.o_m_axis_tlast;
        if (samp_tvalid) begin
            tv_cnt++;
            if (first_tv < 0) first_tv = cyc;
        end
        hs       = bus.o_m_axis_tvalid && bus.i_m_axis_tready;
        exp_done = 1'b0;
        if (hs) begin
            beats++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("tdata", bus.o_m_axis_tdata, e.data);
                check("tlast", bus.o_m_axis_tlast, e.last);
                exp_done = e.last;
            end
        end
        check("pkt_done", pkt_done, exp_done);
        if (pkt_done) dones++;
        rd = bus.o_fifo_rd_en;
        if (rd) begin
            rdens++;
            if (first_rd < 0) first_rd = cyc;
        end
        @(posedge clk);
        #1;
        bus.i_fifo_rd_valid = 1'b0;
        if (rd) begin
            if (fifo_q.size() > 0) begin
                bus.i_fifo_rd_data  = fifo_q.pop_front();
                bus.i_fifo_rd_valid = 1'b1;
            end else begin
                check("rd_en_on_empty", 1, 0);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int eff;
        int gaps;
        int stall_left;
        bit stall_started;
        logic [DW-1:0] w;
        beat_t b;
        clear_stats();
        eff  = (v.len == 0) ? 1 : v.len;
        gaps = 0;
        stall_left = 0;
        stall_started = 1'b0;
        for (int k = 0; k < v.words; k++) begin
            w = DW'(id * 16 + k + 1);
            fifo_q.push_back(w);
            b.data = w;
            b.last = ((k + 1) % eff) == 0;
            sb_q.push_back(b);
        end
        pkt_len = LW'(v.len);
        for (int c = 0; c < 300; c++) begin
            enable    = (c == 0) || (v.hold && (dones < v.exp_pkts - 1));
            ready_now = v.rdy[c % 4];
            if (v.stall_len > 0 && !stall_started && beats >= v.stall_after) begin
                stall_started = 1'b1;
                stall_left    = v.stall_len;
            end
            stall_now = (stall_left > 0);
            tick();
            if (stall_left > 0) begin
                if (stall_left == 1) check("stall_drains_tvalid", samp_tvalid, 0);
                stall_left--;
            end
            if (c > 0 && dones < v.exp_pkts && !samp_busy) gaps++;
            if (dones >= v.exp_pkts && sb_q.size() == 0 && !samp_busy) break;
        end
        enable    = 1'b0;
        stall_now = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("sb_drained", sb_q.size(), 0);
        check("beats", beats, v.words);
        check("pkt_count", dones, v.exp_pkts);
        check("rd_en_count", rdens, v.words);
        check("busy_gaps", gaps, 0);
        check("idle_busy", busy, 0);
        check("latency", first_tv - first_rd, 2);
        if (v.exp_span >= 0) check("span", last_hs - first_hs, v.exp_span);
        sb_q.delete();
        fifo_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len:4, words:4, rdy:4'b1111, hold:0, stall_after:0, stall_len:0, exp_pkts:1, exp_span:3};
        vecs[1] = '{len:3, words:3, rdy:4'b0101, hold:0, stall_after:0, stall_len:0, exp_pkts:1, exp_span:-1};
        vecs[2] = '{len:0, words:1, rdy:4'b1111, hold:0, stall_after:0, stall_len:0, exp_pkts:1, exp_span:0};
        vecs[3] = '{len:2, words:6, rdy:4'b1111, hold:1, stall_after:0, stall_len:0, exp_pkts:3, exp_span:-1};
        vecs[4] = '{len:6, words:6, rdy:4'b1111, hold:0, stall_after:2, stall_len:5, exp_pkts:1, exp_span:-1};
        vecs[5] = '{len:5, words:5, rdy:4'b1011, hold:0, stall_after:0, stall_len:0, exp_pkts:1, exp_span:-1};

        rst = 1'b1;
        enable = 1'b0;
        pkt_len = '0;
        ready_now = 1'b0;
        stall_now = 1'b0;
        bus.i_fifo_empty    = 1'b1;
        bus.i_fifo_rd_data  = '0;
        bus.i_fifo_rd_valid = 1'b0;
        bus.i_m_axis_tready = 1'b0;
        clear_stats();
        @(negedge clk);
        @(negedge clk);
        check("rst_tvalid", bus.o_m_axis_tvalid, 0);
        check("rst_tlast", bus.o_m_axis_tlast, 0);
        check("rst_tdata", bus.o_m_axis_tdata, 0);
        check("rst_rd_en", bus.o_fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_done", pkt_done, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a stalled packet with both buffer entries full.
        clear_stats();
        for (int k = 0; k < 4; k++) fifo_q.push_back(DW'(8'hA0 + k));
        pkt_len   = LW'(4);
        ready_now = 1'b0;
        for (int c = 0; c < 6; c++) begin
            enable = (c == 0);
            tick();
        end
        check("pre_rst_tvalid", samp_tvalid, 1);
        check("pre_rst_busy", samp_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", bus.o_m_axis_tvalid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", bus.o_fifo_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        clear_stats();
        bus.i_fifo_rd_data  = 8'hEE;
        bus.i_fifo_rd_valid = 1'b1;
        ready_now = 1'b1;
        enable    = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("post_rst_stale_beats", tv_cnt, 0);
        check("post_rst_rd_en", rdens, 0);

        run_vec(7, '{len:2, words:2, rdy:4'b1111, hold:0, stall_after:0, stall_len:0, exp_pkts:1, exp_span:1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
